// File: rtl/exu_posit_pkg.sv
// Shared types and constants for the EXU posit sequencers (adder, multiplier).
// The posit width and exponent width here describe the default core configuration.
package exu_posit_pkg;

   localparam int POSIT_N  = 32;
   localparam int POSIT_ES = 2;

   typedef enum logic [1:0] {
      OP_ADD      = 2'b00,
      OP_SUB      = 2'b01,
      OP_ACC_INIT = 2'b10,
      OP_ACC_ADD  = 2'b11
   } posit_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } seq_state_e;

   localparam logic [POSIT_N-1:0] NAR  = {1'b1, {(POSIT_N-1){1'b0}}};
   localparam logic [POSIT_N-1:0] ZERO = '0;
   localparam logic [POSIT_N-1:0] ONE  = {2'b01, {(POSIT_N-2){1'b0}}};

endpackage

// File: rtl/exu_posit_neg.sv
// Posit negation is plain two's complement of the whole word; 0 and NaR map to themselves.
module exu_posit_neg #(
   parameter int N = 32
) (
   input  logic [N-1:0] x,
   output logic [N-1:0] y
);

   assign y = ~x + {{(N-1){1'b0}}, 1'b1};

endmodule

// File: rtl/exu_posit_add_seq.sv
// Issue/sequencing stage in front of the posit adder: registers operands, runs the
// adder handshake, owns the posit accumulator and returns a tagged result.
module exu_posit_add_seq
   import exu_posit_pkg::*;
#(
   parameter int N    = 32,
   parameter int ES   = 2,
   parameter int TAGW = 5
) (
   input  logic            clk,
   input  logic            rst_l,
   input  logic            flush,
   input  logic            valid_in,
   output logic            ready_out,
   input  logic [1:0]      op,
   input  logic [N-1:0]    rs1,
   input  logic [N-1:0]    rs2,
   input  logic [TAGW-1:0] tag_in,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [N-1:0]    res,
   output logic [TAGW-1:0] res_tag,
   output logic            res_nar,
   output logic            res_zero,
   output logic            busy,
   output logic [N-1:0]    add_in1,
   output logic [N-1:0]    add_in2,
   output logic            add_start,
   input  logic [N-1:0]    add_out,
   input  logic            add_inf,
   input  logic            add_zero,
   input  logic            add_done
);

   localparam logic [N-1:0] NAR_V  = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] ZERO_V = '0;
   localparam logic [31:0]  ES_V   = 32'(ES);

   seq_state_e      state, state_nxt;
   posit_op_e       op_q;
   logic [TAGW-1:0] tag_q;
   logic [N-1:0]    opa, opb, acc, res_q;
   logic            nar_q, zero_q;
   logic [N-1:0]    rs2_neg, opa_d, opb_d;
   logic            accept, commit, acc_op;

   // The adder reports its own zero; we derive ours from the result word instead.
   logic unused_inputs;
   assign unused_inputs = ^{add_zero, ES_V[0]};

   exu_posit_neg #(.N(N)) u_neg (
      .x (rs2),
      .y (rs2_neg)
   );

   assign ready_out = (state == ST_IDLE) && !flush;
   assign accept    = valid_in && ready_out;
   assign commit    = (state == ST_EXEC) && add_done && !flush;
   assign acc_op    = (op_q == OP_ACC_INIT) || (op_q == OP_ACC_ADD);

   always_comb begin
      opa_d = rs1;
      opb_d = rs2;
      case (posit_op_e'(op))
         OP_ADD:      opb_d = rs2;
         OP_SUB:      opb_d = rs2_neg;
         OP_ACC_INIT: opb_d = rs2;
         OP_ACC_ADD: begin
            opa_d = acc;
            opb_d = rs1;
         end
         default:     opb_d = rs2;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      add_start = 1'b0;
      res_valid = 1'b0;
      busy      = (state != ST_IDLE);
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_EXEC;
         ST_EXEC: begin
            add_start = 1'b1;
            if (add_done) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Flush overrides everything, including a same-cycle res_ready in RESP.
      if (flush) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         op_q   <= OP_ADD;
         tag_q  <= '0;
         opa    <= '0;
         opb    <= '0;
         acc    <= '0;
         res_q  <= '0;
         nar_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         if (accept) begin
            op_q  <= posit_op_e'(op);
            tag_q <= tag_in;
            opa   <= opa_d;
            opb   <= opb_d;
         end
         if (commit) begin
            res_q  <= add_out;
            nar_q  <= (add_out == NAR_V) || add_inf;
            zero_q <= (add_out == ZERO_V);
            if (acc_op) acc <= add_out;
         end
      end
   end

   // Operand registers only change on accept, so the adder inputs hold outside EXEC.
   assign add_in1  = opa;
   assign add_in2  = opb;
   assign res      = res_q;
   assign res_tag  = tag_q;
   assign res_nar  = nar_q;
   assign res_zero = zero_q;

endmodule

// File: tb/tb_exu_posit_add_seq.sv
// Self-checking bench for exu_posit_add_seq with a behavioural posit adder stub.
module tb_exu_posit_add_seq;

   localparam logic [31:0] P_NAR  = 32'h8000_0000;
   localparam logic [31:0] P_ONE  = 32'h4000_0000;
   localparam logic [1:0]  K_ADD  = 2'b00;
   localparam logic [1:0]  K_SUB  = 2'b01;
   localparam logic [1:0]  K_INIT = 2'b10;
   localparam logic [1:0]  K_ACC  = 2'b11;

   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic        flush = 1'b0;
   logic        valid_in = 1'b0;
   logic        ready_out;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs1 = '0, rs2 = '0;
   logic [4:0]  tag_in = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res;
   logic [4:0]  res_tag;
   logic        res_nar, res_zero, busy;
   logic [31:0] add_in1, add_in2;
   logic        add_start;
   logic [31:0] add_out;
   logic        add_inf, add_zero, add_done;

   int total = 0;
   int bad = 0;
   int lat = 0;
   int cnt;
   logic [31:0] acc_m = '0;
   logic [31:0] last_res;
   logic [31:0] vals[13];

   always #5 clk = ~clk;

   exu_posit_add_seq dut (
      .clk(clk), .rst_l(rst_l), .flush(flush), .valid_in(valid_in), .ready_out(ready_out),
      .op(op), .rs1(rs1), .rs2(rs2), .tag_in(tag_in), .res_valid(res_valid),
      .res_ready(res_ready), .res(res), .res_tag(res_tag), .res_nar(res_nar),
      .res_zero(res_zero), .busy(busy), .add_in1(add_in1), .add_in2(add_in2),
      .add_start(add_start), .add_out(add_out), .add_inf(add_inf), .add_zero(add_zero),
      .add_done(add_done)
   );

   // posit<32,2> -> real (exact for all posit32 values)
   function automatic real dec(input logic [31:0] p0);
      logic [31:0] p;
      logic r, s;
      int m, pos, k, e;
      real f, w, v;
      if (p0 == 32'h0) return 0.0;
      s = p0[31];
      p = s ? (~p0 + 32'd1) : p0;
      pos = 30; r = p[30]; m = 0;
      while (pos >= 0 && p[pos] == r) begin m++; pos--; end
      pos--;
      k = r ? m - 1 : -m;
      e = 0;
      for (int i = 0; i < 2; i++) begin
         e = e * 2 + ((pos >= 0) ? int'(p[pos]) : 0);
         pos--;
      end
      f = 1.0; w = 0.5;
      while (pos >= 0) begin
         if (p[pos]) f = f + w;
         w = w / 2.0; pos--;
      end
      v = f * (2.0 ** (4 * k + e));
      return s ? -v : v;
   endfunction

   // real -> posit<32,2>, exact for the small dyadic values this bench uses
   function automatic logic [31:0] enc(input real v);
      real a;
      int sc, k, e, pos;
      logic [31:0] p;
      logic ng;
      if (v == 0.0) return 32'h0;
      ng = (v < 0.0);
      a = ng ? -v : v;
      sc = 0;
      while (a >= 2.0 && sc < 200) begin a = a / 2.0; sc++; end
      while (a < 1.0 && sc > -200) begin a = a * 2.0; sc--; end
      k = (sc >= 0) ? sc / 4 : -((-sc + 3) / 4);
      e = sc - 4 * k;
      p = '0; pos = 30;
      if (k >= 0) begin
         for (int i = 0; i <= k; i++) begin
            if (pos >= 0) p[pos] = 1'b1;
            pos--;
         end
         pos--;
      end else begin
         pos = pos + k;
         if (pos >= 0) p[pos] = 1'b1;
         pos--;
      end
      for (int i = 1; i >= 0; i--) begin
         if (pos >= 0) p[pos] = e[i];
         pos--;
      end
      a = a - 1.0;
      while (pos >= 0) begin
         a = a * 2.0;
         if (a >= 1.0) begin p[pos] = 1'b1; a = a - 1.0; end
         pos--;
      end
      return ng ? (~p + 32'd1) : p;
   endfunction

   function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      if (a == P_NAR || b == P_NAR) return P_NAR;
      return enc(dec(a) + dec(b));
   endfunction

   // Adder stub: done after 'lat' cycles of held start (lat=0 -> same cycle).
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)          cnt <= 0;
      else if (!add_start) cnt <= 0;
      else                 cnt <= cnt + 1;
   end

   always_comb begin
      add_out  = ref_add(add_in1, add_in2);
      add_inf  = (add_out == P_NAR);
      add_zero = (add_out == 32'h0);
      add_done = add_start && (cnt >= lat);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", name, got, exp);
      end
   endtask

   // Issue one op, follow it through EXEC, hold RESP for 'hold' cycles, then retire it.
   task automatic run_op(input logic [1:0] o, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] tg, input int l, input int hold);
      logic [31:0] ea, eb, er;
      int n;
      case (o)
         K_SUB:   begin ea = r1;    eb = 32'h0 - r2; end
         K_ACC:   begin ea = acc_m; eb = r1;         end
         default: begin ea = r1;    eb = r2;         end
      endcase
      er = ref_add(ea, eb);
      @(negedge clk);
      lat = l; op = o; rs1 = r1; rs2 = r2; tag_in = tg; valid_in = 1'b1;
      #1 chk("ready_idle", 32'(ready_out), 32'd1);
      @(negedge clk);
      valid_in = 1'b0;
      n = 1;
      chk("add_start", 32'(add_start), 32'd1);
      chk("add_in1", add_in1, ea);
      chk("add_in2", add_in2, eb);
      while (!res_valid && n < 20) begin @(negedge clk); n++; end
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("latency", 32'(n), 32'(l + 2));
      chk("res", res, er);
      chk("res_tag", 32'(res_tag), 32'(tg));
      chk("res_nar", 32'(res_nar), 32'(er == P_NAR));
      chk("res_zero", 32'(res_zero), 32'(er == 32'h0));
      if (o[1]) acc_m = er;
      last_res = res;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_res", res, er);
         chk("hold_tag", 32'(res_tag), 32'(tg));
         chk("hold_valid", 32'(res_valid), 32'd1);
         chk("hold_ready", 32'(ready_out), 32'd0);
         chk("hold_busy", 32'(busy), 32'd1);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      #1;
      chk("retire_valid", 32'(res_valid), 32'd0);
      chk("retire_ready", 32'(ready_out), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vals = '{enc(0.0), enc(0.5), enc(1.0), enc(1.5), enc(2.0), enc(3.0), enc(4.0),
               enc(-0.5), enc(-1.0), enc(-1.5), enc(-2.0), enc(-3.0), enc(-4.0)};
      #12;
      chk("rst_ready", 32'(ready_out), 32'd1);
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_start", 32'(add_start), 32'd0);
      chk("rst_res", res, 32'h0);
      chk("rst_in1", add_in1, 32'h0);
      @(negedge clk);
      rst_l = 1'b1;

      // Directed arithmetic cases
      run_op(K_ADD, P_ONE, P_ONE, 5'd3, 0, 0);
      chk("one_plus_one", last_res, 32'h4800_0000);
      run_op(K_SUB, P_ONE, P_ONE, 5'd4, 0, 0);
      chk("one_minus_one", last_res, 32'h0);
      chk("zero_flag", 32'(res_zero), 32'd1);
      run_op(K_SUB, P_ONE, 32'hC000_0000, 5'd5, 1, 0);
      chk("one_minus_neg1", last_res, 32'h4800_0000);
      run_op(K_ADD, P_NAR, P_ONE, 5'd6, 0, 0);
      chk("nar_add", last_res, P_NAR);
      chk("nar_flag", 32'(res_nar), 32'd1);
      run_op(K_INIT, P_NAR, P_ONE, 5'd7, 0, 0);
      run_op(K_ACC, P_ONE, 32'h0, 5'd8, 2, 0);
      chk("nar_sticky", last_res, P_NAR);
      run_op(K_INIT, P_ONE, P_ONE, 5'd9, 0, 0);
      chk("acc_init", last_res, 32'h4800_0000);
      run_op(K_ACC, 32'h4800_0000, 32'h0, 5'd10, 0, 3);
      chk("acc_add", last_res, 32'h5000_0000);
      run_op(K_ACC, 32'h0, 32'h0, 5'd11, 3, 0);
      chk("acc_value", last_res, 32'h5000_0000);

      // Flush in EXEC during a slow ACC_ADD, then coincident with done
      for (int l = 2; l >= 0; l -= 2) begin
         @(negedge clk);
         lat = l; op = K_ACC; rs1 = P_ONE; valid_in = 1'b1;
         @(negedge clk);
         valid_in = 1'b0; flush = 1'b1;
         #1 chk("flush_ready_low", 32'(ready_out), 32'd0);
         @(negedge clk);
         flush = 1'b0;
         #1;
         chk("flush_busy", 32'(busy), 32'd0);
         chk("flush_valid", 32'(res_valid), 32'd0);
         chk("flush_ready", 32'(ready_out), 32'd1);
         @(negedge clk);
         chk("flush_novalid", 32'(res_valid), 32'd0);
         run_op(K_ACC, 32'h0, 32'h0, 5'd12, 0, 0);
         chk("flush_acc_kept", last_res, 32'h5000_0000);
      end

      // Flush in RESP discards the result, even with res_ready high
      @(negedge clk);
      lat = 0; op = K_ADD; rs1 = P_ONE; rs2 = P_ONE; valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      @(negedge clk);
      chk("pre_flush_valid", 32'(res_valid), 32'd1);
      flush = 1'b1; res_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; res_ready = 1'b0;
      #1;
      chk("resp_flush_valid", 32'(res_valid), 32'd0);
      chk("resp_flush_busy", 32'(busy), 32'd0);

      // Flush in IDLE blocks acceptance
      @(negedge clk);
      valid_in = 1'b1; flush = 1'b1;
      #1 chk("idle_flush_ready", 32'(ready_out), 32'd0);
      @(negedge clk);
      valid_in = 1'b0; flush = 1'b0;
      chk("idle_flush_busy", 32'(busy), 32'd0);

      // Asynchronous reset in the middle of EXEC
      @(negedge clk);
      lat = 3; op = K_ACC; rs1 = P_ONE; valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_l = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ready", 32'(ready_out), 32'd1);
      chk("arst_start", 32'(add_start), 32'd0);
      chk("arst_in1", add_in1, 32'h0);
      chk("arst_res", res, 32'h0);
      chk("arst_tag", 32'(res_tag), 32'd0);
      acc_m = 32'h0;
      @(negedge clk);
      rst_l = 1'b1;
      run_op(K_ACC, P_ONE, 32'h0, 5'd13, 0, 0);
      chk("acc_after_rst", last_res, P_ONE);

      // Randomized op mix against the model
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         a = ($urandom_range(0, 19) == 0) ? P_NAR : vals[$urandom_range(0, 12)];
         b = vals[$urandom_range(0, 12)];
         run_op(2'($urandom_range(0, 3)), a, b, 5'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exu_posit_add_seq.md
Name: exu_posit_add_seq

Overview:
- Issue/sequencing stage directly upstream of the posit adder in the EXU.
- Accepts posit add/sub/accumulate ops from decode with a valid/ready handshake and registers the operands.
- Drives the adder's operand and start inputs and captures its output, flags and done.
- Returns a tagged result through a valid/ready response port and owns the architectural posit accumulator register.

Parameters:
- N, 32, posit width.
- ES, 2, exponent field width; passed through to the package constants only.
- TAGW, 5, destination tag width.

Ports:
- clk  in  1  core clock.
- rst_l  in  1  reset; asynchronous assert, active-low.
- flush  in  1  kill in-flight op.
- valid_in  in  1  op request.
- ready_out  out  1  request accepted when valid_in&ready_out.
- op  in  2  00 ADD, 01 SUB, 10 ACC_INIT (acc:=rs1+rs2), 11 ACC_ADD (acc:=acc+rs1).
- rs1  in  N  operand 1.
- rs2  in  N  operand 2; ignored for ACC_ADD.
- tag_in  in  TAGW  destination tag.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res  out  N  posit result.
- res_tag  out  TAGW  tag of result.
- res_nar  out  1  res==NaR.
- res_zero  out  1  res==0.
- busy  out  1  state != IDLE.
- add_in1  out  N  adder operand 1.
- add_in2  out  N  adder operand 2.
- add_start  out  1  adder start.
- add_out  in  N  adder result.
- add_inf  in  1  adder NaR flag.
- add_zero  in  1  adder zero flag; unused.
- add_done  in  1  adder done.

Behaviour:
- Reset (rst_l low, asynchronous): state=IDLE, all outputs 0 except ready_out=1, acc=0, operand/result regs=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - ready_out = ~flush.
  - On valid_in&ready_out, capture op/tag and form operands:
    - ADD: opa=rs1, opb=rs2.
    - SUB: opa=rs1, opb=neg(rs2).
    - ACC_INIT: opa=rs1, opb=rs2.
    - ACC_ADD: opa=acc, opb=rs1.
  - Transition to EXEC.
- neg(x) = N-bit two's complement; 0 maps to 0 and NaR (1 followed by N-1 zeros) maps to NaR, with no special casing needed.
- EXEC:
  - add_start=1, add_in1=opa, add_in2=opb.
  - On the first cycle add_done=1: latch res=add_out, set res_nar=(add_out==NaR) or add_inf, set res_zero=(add_out==0).
  - For ACC ops, acc:=add_out on that same edge.
  - Transition to RESP.
  - Outside EXEC, add_start=0 and add_in1/add_in2 hold their last values.
- RESP:
  - res_valid=1; res, res_tag, res_nar, res_zero stable until res_ready.
  - On res_ready go to IDLE; no new accept in that cycle.
- Latency, with a combinational adder (done same cycle as start): accept at edge t, EXEC cycle t+1, res_valid from t+2. Minimum issue interval is 3 cycles.
- With a multi-cycle adder, EXEC holds add_start and operands stable until add_done.
- flush, highest priority:
  - In any state, the next state is IDLE and res_valid drops next cycle.
  - If flush coincides with add_done in EXEC, acc and res are NOT updated.
  - flush in RESP discards the pending result.
  - flush in IDLE blocks acceptance.
  - acc is never cleared by flush.
- Simultaneous res_ready and flush in RESP: behaves as flush (result treated as not delivered).
- NaR is sticky through the accumulator via adder semantics: acc stays NaR until ACC_INIT.
- No width growth: all datapaths are N bits; tag is passed through unchanged.

Decomposition:
- Shared package exu_posit_pkg:
  - op encoding enum (ADD, SUB, ACC_INIT, ACC_ADD);
  - FSM state enum;
  - NAR and ZERO constants derived from N;
  - ONE constant (0x40000000 at N=32).
- Sub-module exu_posit_neg: combinational N-bit two's-complement negate, reused by the SUB path and later by the multiplier sequencer.

Test Plan:
- ADD rs1=0x40000000, rs2=0x40000000, tag=3 → res_valid at t+2, res=0x48000000, res_tag=3, res_nar=0, res_zero=0.
- SUB rs1=0x40000000, rs2=0x40000000 → res=0x00000000, res_zero=1. SUB rs1=0x40000000, rs2=0xC0000000 → res=0x48000000.
- ADD rs1=0x80000000, rs2=0x40000000 → res=0x80000000, res_nar=1. Then ACC_ADD after an ACC_INIT with a NaR operand → res remains 0x80000000.
- ACC_INIT rs1=rs2=0x40000000 → res=0x48000000. Then ACC_ADD rs1=0x48000000 → res=0x50000000, and acc=0x50000000.
- Backpressure: hold res_ready=0 for 3 cycles in RESP → res/res_tag stable, ready_out=0, busy=1. Raise res_ready → IDLE next cycle, ready_out=1.
- Flush in EXEC during ACC_ADD → no res_valid, acc unchanged, ready_out=1 the cycle after flush deasserts. Also: rst_l pulsed low mid-EXEC → all outputs at reset values immediately, acc=0.
